// File: rtl/mul4_fit_pkg.sv
// Shared types and the 2x2-bit golden multiplier used by the fitness evaluator.
// Operands and products are bit-sliced: lane i of every 16-bit word is one independent multiply.
package mul4_fit_pkg;

  localparam int LANES         = 16;
  localparam int BITS_PER_WORD = 64;
  localparam int CNT_W         = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } fit_state_e;

  // Product word ordered {p3, p2, p1, p0}, one 16-lane slice per product bit.
  function automatic logic [BITS_PER_WORD-1:0] golden_prod(
    input logic [LANES-1:0] a1,
    input logic [LANES-1:0] a0,
    input logic [LANES-1:0] b1,
    input logic [LANES-1:0] b0
  );
    logic [LANES-1:0] g3, g2, g1, g0;
    g0 = a0 & b0;
    g1 = (a1 & b0) ^ (a0 & b1);
    g2 = a1 & b1 & ~(a0 & b0);
    g3 = a1 & a0 & b1 & b0;
    return {g3, g2, g1, g0};
  endfunction

endpackage

// File: rtl/mul4_golden_cmp.sv
// Compares a candidate 16-lane product word against the golden product; purely combinational.
// Returns the per-bit match vector ({y3,y2,y1,y0} order) and its popcount (0..64).
module mul4_golden_cmp
  import mul4_fit_pkg::*;
(
  input  logic [LANES-1:0]         a1,
  input  logic [LANES-1:0]         a0,
  input  logic [LANES-1:0]         b1,
  input  logic [LANES-1:0]         b0,
  input  logic [LANES-1:0]         y3,
  input  logic [LANES-1:0]         y2,
  input  logic [LANES-1:0]         y1,
  input  logic [LANES-1:0]         y0,
  output logic [BITS_PER_WORD-1:0] match_vec,
  output logic [CNT_W-1:0]         match_cnt
);

  logic [BITS_PER_WORD-1:0] gold;

  always_comb begin
    gold      = golden_prod(a1, a0, b1, b0);
    match_vec = ~({y3, y2, y1, y0} ^ gold);
    match_cnt = '0;
    for (int i = 0; i < BITS_PER_WORD; i++) begin
      match_cnt = match_cnt + CNT_W'(match_vec[i]);
    end
  end

endmodule

// File: rtl/mul4_fitness_eval.sv
// Scores an evolved 2x2 multiplier over NUM_WORDS bit-sliced words; score lands 2 cycles after each accept, done 3 cycles after the last.
// in_ready only in RUN (no stall inside RUN); MUL4_FIT_ERRMASK_EN adds the accumulated err_mask output.
module mul4_fitness_eval
  import mul4_fit_pkg::*;
#(
  parameter  int NUM_WORDS = 1,
  localparam int SW        = $clog2(BITS_PER_WORD * NUM_WORDS + 1),
  localparam int CW        = $clog2(NUM_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] a1,
  input  logic [LANES-1:0] a0,
  input  logic [LANES-1:0] b1,
  input  logic [LANES-1:0] b0,
  input  logic [LANES-1:0] y3,
  input  logic [LANES-1:0] y2,
  input  logic [LANES-1:0] y1,
  input  logic [LANES-1:0] y0,
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    score,
  output logic             perfect
`ifdef MUL4_FIT_ERRMASK_EN
  ,
  output logic [BITS_PER_WORD-1:0] err_mask
`endif
);

  fit_state_e         state_q, state_d;
  logic [CW-1:0]      word_cnt_q, word_cnt_d;
  logic               drain_cnt_q, drain_cnt_d;
  logic               s1_vld_q, s1_vld_d;
  logic [CNT_W-1:0]   s1_cnt_q, s1_cnt_d;
  logic [SW-1:0]      score_q, score_d;
  logic               all_match_q, all_match_d;
  logic               perfect_q, perfect_d;
`ifdef MUL4_FIT_ERRMASK_EN
  logic [BITS_PER_WORD-1:0] err_mask_q, err_mask_d;
`endif

  logic [BITS_PER_WORD-1:0] match_vec;
  logic [CNT_W-1:0]         match_cnt;
  logic                     accept;
  logic                     last_beat;

  mul4_golden_cmp u_cmp (
    .a1        (a1),
    .a0        (a0),
    .b1        (b1),
    .b0        (b0),
    .y3        (y3),
    .y2        (y2),
    .y1        (y1),
    .y0        (y0),
    .match_vec (match_vec),
    .match_cnt (match_cnt)
  );

  assign in_ready  = (state_q == ST_RUN);
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (word_cnt_q == CW'(NUM_WORDS - 1));
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign score     = score_q;
  assign perfect   = perfect_q;
`ifdef MUL4_FIT_ERRMASK_EN
  assign err_mask  = err_mask_q;
`endif

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    drain_cnt_d = drain_cnt_q;
    s1_vld_d    = accept;
    s1_cnt_d    = accept ? match_cnt : s1_cnt_q;
    score_d     = score_q;
    all_match_d = all_match_q;
    perfect_d   = perfect_q;
`ifdef MUL4_FIT_ERRMASK_EN
    err_mask_d  = err_mask_q;
    if (accept) err_mask_d = err_mask_q | ~match_vec;
`endif

    if (s1_vld_q) score_d = score_q + SW'(s1_cnt_q);
    // A sticky all-bits-match flag gives perfect without a wide compare against the maximum score.
    if (accept) all_match_d = all_match_q & (&match_vec);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          word_cnt_d  = '0;
          score_d     = '0;
          all_match_d = 1'b1;
          perfect_d   = 1'b0;
`ifdef MUL4_FIT_ERRMASK_EN
          err_mask_d  = '0;
`endif
        end
      end
      ST_RUN: begin
        if (last_beat) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 1'b0;
        end else if (accept) begin
          word_cnt_d = word_cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q) begin
          state_d   = ST_DONE;
          perfect_d = all_match_q;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      drain_cnt_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_cnt_q    <= '0;
      score_q     <= '0;
      all_match_q <= 1'b0;
      perfect_q   <= 1'b0;
`ifdef MUL4_FIT_ERRMASK_EN
      err_mask_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_cnt_q    <= s1_cnt_d;
      score_q     <= score_d;
      all_match_q <= all_match_d;
      perfect_q   <= perfect_d;
`ifdef MUL4_FIT_ERRMASK_EN
      err_mask_q  <= err_mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_mul4_fitness_eval.sv
// Bench for mul4_fitness_eval: one-word and two-word instances, scoreboard of expected scores per run.
`timescale 1ns/1ps
module tb_mul4_fitness_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start1, start2, iv1, iv2;
  logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
  logic        ir1, busy1, done1, perf1;
  logic [6:0]  score1;
  logic        ir2, busy2, done2, perf2;
  logic [7:0]  score2;
`ifdef MUL4_FIT_ERRMASK_EN
  logic [63:0] em1, em2;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done1_cnt = 0;
  int done2_cnt = 0;
  int acc_cyc = 0;

  int sb_score[$];
  bit sb_perf[$];

  logic [15:0] wa1[4], wa0[4], wb1[4], wb0[4];
  logic [63:0] wy[4];

  mul4_fitness_eval #(.NUM_WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(iv1), .in_ready(ir1),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .busy(busy1), .done(done1), .score(score1), .perfect(perf1)
`ifdef MUL4_FIT_ERRMASK_EN
    , .err_mask(em1)
`endif
  );

  mul4_fitness_eval #(.NUM_WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(iv2), .in_ready(ir2),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .busy(busy2), .done(done2), .score(score2), .perfect(perf2)
`ifdef MUL4_FIT_ERRMASK_EN
    , .err_mask(em2)
`endif
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done1) done1_cnt <= done1_cnt + 1;
    if (done2) done2_cnt <= done2_cnt + 1;
  end

  // Reference product via integer multiply per lane, laid out {p3,p2,p1,p0}.
  function automatic logic [63:0] model_prod(input logic [15:0] ma1, input logic [15:0] ma0,
                                             input logic [15:0] mb1, input logic [15:0] mb0);
    logic [63:0] r;
    int p;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      p = int'({ma1[i], ma0[i]}) * int'({mb1[i], mb0[i]});
      for (int k = 0; k < 4; k++) r[k*16 + i] = p[k];
    end
    return r;
  endfunction

  task automatic set_exhaustive(input int w);
    wa0[w] = 16'hAAAA; wa1[w] = 16'hCCCC; wb0[w] = 16'hF0F0; wb1[w] = 16'hFF00;
  endtask

  task automatic set_random(input int w);
    wa0[w] = 16'($urandom); wa1[w] = 16'($urandom); wb0[w] = 16'($urandom); wb1[w] = 16'($urandom);
  endtask

  // Starts a run on dut<sel>, feeds nw words with gap idle cycles before each, pushes expectations.
  task automatic drive_run(input int sel, input int nw, input int gap);
    int exp;
    logic [63:0] g;
    exp = 0;
    @(posedge clk); #1;
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < gap; k++) begin
        @(posedge clk); #1;
      end
      a1 = wa1[w]; a0 = wa0[w]; b1 = wb1[w]; b0 = wb0[w];
      {y3, y2, y1, y0} = wy[w];
      if (sel == 1) iv1 = 1'b1; else iv2 = 1'b1;
      @(posedge clk); #1;
      acc_cyc = cyc;
      iv1 = 1'b0; iv2 = 1'b0;
      g = model_prod(wa1[w], wa0[w], wb1[w], wb0[w]);
      exp += $countones(~(wy[w] ^ g));
    end
    sb_score.push_back(exp);
    sb_perf.push_back(exp == 64 * nw);
  endtask

  task automatic wait_done(input int sel, output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel == 1 && done1) || (sel == 2 && done2)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ir1 !== 1'b0 || ir2 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b/%b expected 0/0", ir1, ir2); end
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b expected 0/0", busy1, busy2); end
    checks++; if (done1 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b/%b expected 0/0", done1, done2); end
    checks++; if (score1 !== 7'd0 || score2 !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d/%0d expected 0/0", score1, score2); end
    checks++; if (perf1 !== 1'b0 || perf2 !== 1'b0) begin errors++; $display("FAIL reset_perfect: got %b/%b expected 0/0", perf1, perf2); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy1 !== 1'b0 || ir1 !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy=%b ready=%b expected 0/0", busy1, ir1); end
  endtask

  task automatic test_golden_single();
    bit found;
    int es;
    bit ep;
    set_exhaustive(0);
    wy[0] = model_prod(wa1[0], wa0[0], wb1[0], wb0[0]);
    drive_run(1, 1, 0);
    checks++; if (ir1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL drain_flags: ready=%b busy=%b expected 0/1", ir1, busy1); end
    wait_done(1, found);
    es = sb_score.pop_front(); ep = sb_perf.pop_front();
    checks++; if (!found) begin errors++; $display("FAIL golden1_done_timeout: no done within 20 cycles"); end
    // Accept cycle is cycle 0; done is visible in cycle 3, i.e. after the second edge past the accept edge.
    checks++; if (cyc - acc_cyc != 2) begin errors++; $display("FAIL golden1_latency: got %0d edges after accept expected 2", cyc - acc_cyc); end
    checks++; if (score1 !== 7'(es)) begin errors++; $display("FAIL golden1_score: got %0d expected %0d", score1, es); end
    checks++; if (perf1 !== ep) begin errors++; $display("FAIL golden1_perfect: got %b expected %b", perf1, ep); end
    @(negedge clk);
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL golden1_done_pulse: done=%b busy=%b expected 0/0", done1, busy1); end
    repeat (3) @(negedge clk);
    checks++; if (score1 !== 7'(es) || perf1 !== ep) begin errors++; $display("FAIL golden1_hold: got %0d/%b expected %0d/%b", score1, perf1, es, ep); end
  endtask

  task automatic test_all_zero();
    bit found;
    int es;
    bit ep;
    set_exhaustive(0);
    wy[0] = 64'h0;
    drive_run(1, 1, 0);
    checks++; if (perf1 !== 1'b0) begin errors++; $display("FAIL zero_perfect_cleared: got %b expected 0", perf1); end
    wait_done(1, found);
    es = sb_score.pop_front(); ep = sb_perf.pop_front();
    checks++; if (!found) begin errors++; $display("FAIL zero_done_timeout: no done within 20 cycles"); end
    checks++; if (score1 !== 7'(es)) begin errors++; $display("FAIL zero_score: got %0d expected %0d", score1, es); end
    checks++; if (perf1 !== ep) begin errors++; $display("FAIL zero_perfect: got %b expected %b", perf1, ep); end
  endtask

  task automatic test_two_words_bubbles();
    bit found;
    int es, d0;
    bit ep;
    set_exhaustive(0);
    set_random(1);
    for (int w = 0; w < 2; w++) wy[w] = model_prod(wa1[w], wa0[w], wb1[w], wb0[w]);
    d0 = done2_cnt;
    drive_run(2, 2, 1);
    wait_done(2, found);
    es = sb_score.pop_front(); ep = sb_perf.pop_front();
    checks++; if (!found) begin errors++; $display("FAIL two_done_timeout: no done within 20 cycles"); end
    checks++; if (score2 !== 8'(es)) begin errors++; $display("FAIL two_score: got %0d expected %0d", score2, es); end
    checks++; if (perf2 !== ep) begin errors++; $display("FAIL two_perfect: got %b expected %b", perf2, ep); end
    repeat (8) @(negedge clk);
    checks++; if (done2_cnt != d0 + 1) begin errors++; $display("FAIL two_done_count: got %0d expected %0d", done2_cnt - d0, 1); end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    int es, d0;
    bit ep;
    set_exhaustive(0);
    set_exhaustive(1);
    for (int w = 0; w < 2; w++) wy[w] = model_prod(wa1[w], wa0[w], wb1[w], wb0[w]);
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    a1 = wa1[0]; a0 = wa0[0]; b1 = wb1[0]; b0 = wb0[0];
    {y3, y2, y1, y0} = wy[0];
    iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (score2 !== 8'd64 || busy2 !== 1'b1) begin errors++; $display("FAIL midrun_partial: score=%0d busy=%b expected 64/1", score2, busy2); end
    d0 = done2_cnt;
    rst = 1'b1;
    #1;
    checks++; if (score2 !== 8'd0 || perf2 !== 1'b0) begin errors++; $display("FAIL midrun_reset_score: got %0d/%b expected 0/0", score2, perf2); end
    checks++; if (busy2 !== 1'b0 || ir2 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL midrun_reset_flags: busy=%b ready=%b done=%b expected 0/0/0", busy2, ir2, done2); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (done2_cnt != d0 || busy2 !== 1'b0) begin errors++; $display("FAIL midrun_no_done: done pulses=%0d busy=%b expected 0/0", done2_cnt - d0, busy2); end
    drive_run(2, 2, 0);
    wait_done(2, found);
    es = sb_score.pop_front(); ep = sb_perf.pop_front();
    checks++; if (!found) begin errors++; $display("FAIL midrun_rerun_timeout: no done within 20 cycles"); end
    checks++; if (score2 !== 8'(es) || perf2 !== ep) begin errors++; $display("FAIL midrun_rerun: got %0d/%b expected %0d/%b", score2, perf2, es, ep); end
  endtask

  task automatic test_start_in_drain();
    bit found;
    int es, d0;
    bit ep;
    set_random(0);
    wy[0] = model_prod(wa1[0], wa0[0], wb1[0], wb0[0]);
    d0 = done1_cnt;
    drive_run(1, 1, 0);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(1, found);
    es = sb_score.pop_front(); ep = sb_perf.pop_front();
    checks++; if (!found) begin errors++; $display("FAIL drain_start_timeout: no done within 20 cycles"); end
    checks++; if (score1 !== 7'(es) || perf1 !== ep) begin errors++; $display("FAIL drain_start_score: got %0d/%b expected %0d/%b", score1, perf1, es, ep); end
    repeat (8) @(negedge clk);
    checks++; if (done1_cnt != d0 + 1 || busy1 !== 1'b0) begin errors++; $display("FAIL drain_start_single: done pulses=%0d busy=%b expected 1/0", done1_cnt - d0, busy1); end
  endtask

  task automatic test_back_to_back();
    bit found;
    int es;
    bit ep;
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 2; w++) begin
        set_random(w);
        wy[w] = model_prod(wa1[w], wa0[w], wb1[w], wb0[w]);
        if (r != 0) wy[w] = wy[w] ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      end
      drive_run(2, 2, r % 2);
      wait_done(2, found);
      es = sb_score.pop_front(); ep = sb_perf.pop_front();
      checks++; if (!found) begin errors++; $display("FAIL b2b_timeout run %0d: no done within 20 cycles", r); end
      checks++; if (score2 !== 8'(es) || perf2 !== ep) begin errors++; $display("FAIL b2b_score run %0d: got %0d/%b expected %0d/%b", r, score2, perf2, es, ep); end
    end
  endtask

`ifdef MUL4_FIT_ERRMASK_EN
  task automatic test_errmask();
    bit found;
    int es;
    bit ep;
    logic [63:0] exp_em;
    set_exhaustive(0);
    exp_em = 64'd1 << (16 + 5);
    wy[0] = model_prod(wa1[0], wa0[0], wb1[0], wb0[0]) ^ exp_em;
    drive_run(1, 1, 0);
    wait_done(1, found);
    es = sb_score.pop_front(); ep = sb_perf.pop_front();
    checks++; if (!found) begin errors++; $display("FAIL errmask_timeout: no done within 20 cycles"); end
    checks++; if (score1 !== 7'(es) || perf1 !== ep) begin errors++; $display("FAIL errmask_score: got %0d/%b expected %0d/%b", score1, perf1, es, ep); end
    checks++; if (em1 !== exp_em) begin errors++; $display("FAIL errmask_value: got %h expected %h", em1, exp_em); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start1 = 1'b0; start2 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    a1 = '0; a0 = '0; b1 = '0; b0 = '0; y3 = '0; y2 = '0; y1 = '0; y0 = '0;
    test_reset();
    test_golden_single();
    test_all_zero();
    test_two_words_bubbles();
    test_reset_mid_run();
    test_start_in_drain();
    test_back_to_back();
`ifdef MUL4_FIT_ERRMASK_EN
    test_errmask();
`endif
    checks++; if (sb_score.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_score.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul4_fitness_eval.md
MUL4_FITNESS_EVAL -- requirements
Module: mul4_fitness_eval

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 1, meaning number of 16-lane operand/result words per evaluation run (legal 1..256).
REQ-002 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have start  input  1  begin a new evaluation run.
REQ-005 SHALL have in_valid  input  1  operand/result word present.
REQ-006 SHALL have in_ready  output  1  word accepted when in_valid && in_ready.
REQ-007 SHALL have a1, a0, b1, b0  input  16 each  bit-sliced 2-bit operands, lane i = bit i.
REQ-008 SHALL have y3, y2, y1, y0  input  16 each  candidate product bits from the evolved multiplier under test.
REQ-009 SHALL have busy  output  1  run in progress.
REQ-010 SHALL have done  output  1  one-cycle pulse when score is final.
REQ-011 SHALL have score  output  SW = clog2(64*NUM_WORDS+1)  count of matching product bits.
REQ-012 SHALL have perfect  output  1  score equals 64*NUM_WORDS.

Function
REQ-013 SHALL compute golden per lane: g0=a0&b0; g1=(a1&b0)^(a0&b1); g2=a1&b1&~(a0&b0); g3=a1&a0&b1&b0.
REQ-014 SHALL count per word the matching bits, popcount(~(y^g)) over 64 bits, range 0..64.
REQ-015 SHALL be pipelined: stage 1 registers word match count; stage 2 adds it to score; accepted word reflected in score 2 cycles after acceptance.
REQ-016 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start -> RUN, clears score and word counter; in_ready=0.
REQ-018 RUN: in_ready=1; each accepted beat increments word counter; beat accepted with counter=NUM_WORDS-1 -> DRAIN.
REQ-019 in_valid low in RUN SHALL insert bubbles only; no count, no state change.
REQ-020 DRAIN SHALL last exactly 2 cycles then -> DONE; in_ready=0.
REQ-021 DONE SHALL assert done for exactly one cycle then -> IDLE.
REQ-022 busy SHALL be 1 in RUN, DRAIN, DONE; 0 in IDLE.
REQ-023 start while busy SHALL be ignored.
REQ-024 score and perfect SHALL hold last final value in IDLE until next start; perfect valid only from done cycle on, 0 otherwise.
REQ-025 word counter SHALL be clog2(NUM_WORDS+1) wide and never wrap past NUM_WORDS-1 within a run.

Reset
REQ-026 rst SHALL force state IDLE, in_ready=0, busy=0, done=0, score=0, perfect=0, pipeline valid flags=0, counter=0, immediately and independent of clk.
REQ-027 rst mid-run SHALL abandon the run; no done pulse; next start begins a clean run.

Configuration
REQ-028 With MUL4_FIT_ERRMASK_EN defined, SHALL add output err_mask 16 bits x 4 (per output bit, per lane) = OR of (y^g) over all accepted words, cleared on start/reset, final at done.
REQ-029 Without MUL4_FIT_ERRMASK_EN, err_mask port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package mul4_fit_pkg SHALL hold FSM state enum, lane width constant 16, bits-per-word constant 64, and golden-function helper.
REQ-031 Sub-module mul4_golden_cmp SHALL be combinational: operands + y in, 64-bit match vector and 7-bit popcount out.

Verification
REQ-032 NUM_WORDS=1; a0=0xAAAA, a1=0xCCCC, b0=0xF0F0, b1=0xFF00, y=golden -> done 3 cycles after accept, score=64, perfect=1.
REQ-033 Same operands, y3..y0 all 0x0000 -> score=50, perfect=0.
REQ-034 NUM_WORDS=2, in_valid toggled every other cycle, both words golden -> score=128, perfect=1, done once.
REQ-035 rst asserted in RUN after first of two words -> outputs zero at once, no done; new run with golden words -> score=128.
REQ-036 start pulsed during DRAIN -> ignored, single done, score unaffected.
REQ-037 With MUL4_FIT_ERRMASK_EN, lane 5 of y1 inverted on exhaustive word -> score=63, err_mask y1 field=0x0020, other fields 0.
